// File: rtl/hilo_mult_seq_pkg.sv
// rtl/hilo_mult_seq_pkg.sv - shared types and constants for the HI/LO multiply sequencer
package hilo_mult_seq_pkg;

    localparam int WORD_W       = 32;
    localparam int DWORD_W      = 64;
    localparam int MULT_STATE_W = 2;

    typedef logic [WORD_W-1:0]       word_bus_t;
    typedef logic [DWORD_W-1:0]      dword_bus_t;
    typedef logic [MULT_STATE_W-1:0] mult_state_bus_t;

    localparam logic      ENABLE    = 1'b1;
    localparam logic      DISABLE   = 1'b0;
    localparam word_bus_t ZERO_WORD = '0;

    typedef enum logic [MULT_STATE_W-1:0] {
        MULT_IDLE = 2'b00,
        MULT_RUN  = 2'b01,
        MULT_DONE = 2'b10
    } mult_state_t;

    function automatic int mult_steps(input int width, input int bits_per_cycle);
        return width / bits_per_cycle;
    endfunction

endpackage

// File: rtl/hilo_mult_seq_mult_step.sv
// rtl/hilo_mult_seq_mult_step.sv - combinational partial-product adder: acc + (mcand * digit) << shift
module mult_step
    import hilo_mult_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DIGIT_W = 2,
    parameter int SH_W    = 6
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [DIGIT_W-1:0] digit,
    input  logic [SH_W-1:0]    shift,
    output logic [2*WIDTH-1:0] acc_nxt
);

    logic [2*WIDTH-1:0] partial;

    always_comb begin
        partial = {{WIDTH{1'b0}}, mcand} * {{(2*WIDTH-DIGIT_W){1'b0}}, digit};
        acc_nxt = acc + (partial << shift);
    end

endmodule

// File: rtl/hilo_mult_seq.sv
// rtl/hilo_mult_seq.sv - iterative MULT/MULTU sequencer writing HI/LO; MULT_EARLY_OUT_EN ends RUN once the multiplier is exhausted
module hilo_mult_seq
    import hilo_mult_seq_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_srcLeft,
    input  logic [WIDTH-1:0] i_srcRight,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_busy,
    output logic             o_hiloWriteEnable,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int STEPS = mult_steps(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = $clog2(STEPS + 1);
    localparam int SH_W  = $clog2(2 * WIDTH);

    mult_state_t        state, state_nxt;
    logic [WIDTH-1:0]   mcand, mplier, mplier_nxt;
    logic [2*WIDTH-1:0] acc, acc_nxt, product;
    logic [CNT_W-1:0]   cnt, step_idx;
    logic [SH_W-1:0]    shift_amt;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               neg, last_step, start_ok;

    // Magnitudes stay unsigned so that -2^(WIDTH-1) maps onto 2^(WIDTH-1) without overflow.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    assign start_ok   = i_start && !i_flush;
    assign mplier_nxt = mplier >> BITS_PER_CYCLE;
    assign step_idx   = CNT_W'(STEPS) - cnt;
    assign shift_amt  = SH_W'(step_idx) * SH_W'(BITS_PER_CYCLE);
    assign product    = neg ? (~acc + (2*WIDTH)'(1)) : acc;

    mult_step #(
        .WIDTH  (WIDTH),
        .DIGIT_W(BITS_PER_CYCLE),
        .SH_W   (SH_W)
    ) u_mult_step (
        .acc    (acc),
        .mcand  (mcand),
        .digit  (mplier[BITS_PER_CYCLE-1:0]),
        .shift  (shift_amt),
        .acc_nxt(acc_nxt)
    );

`ifdef MULT_EARLY_OUT_EN
    assign last_step = (cnt == CNT_W'(1)) || (mplier_nxt == '0);
`else
    assign last_step = (cnt == CNT_W'(1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MULT_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MULT_IDLE: if (start_ok) state_nxt = MULT_RUN;
            MULT_RUN: begin
                if (i_flush) begin
                    state_nxt = MULT_IDLE;
                end else if (last_step) begin
                    state_nxt = MULT_DONE;
                end
            end
            MULT_DONE: state_nxt = MULT_IDLE;
            default:   state_nxt = MULT_IDLE;
        endcase
    end

    // A flush in DONE does not cancel the write: the instruction has already committed.
    always_comb begin
        o_stall           = DISABLE;
        o_busy            = (state != MULT_IDLE);
        o_hiloWriteEnable = DISABLE;
        case (state)
            MULT_IDLE: o_stall = start_ok;
            MULT_RUN:  o_stall = !i_flush;
            MULT_DONE: o_hiloWriteEnable = ENABLE;
            default:   o_stall = DISABLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            hi_q   <= ZERO_WORD[WIDTH-1:0];
            lo_q   <= ZERO_WORD[WIDTH-1:0];
        end else begin
            case (state)
                MULT_IDLE: begin
                    if (start_ok) begin
                        mcand  <= magnitude(i_srcLeft, i_signed);
                        mplier <= magnitude(i_srcRight, i_signed);
                        neg    <= i_signed && (i_srcLeft[WIDTH-1] ^ i_srcRight[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= CNT_W'(STEPS);
                    end
                end
                MULT_RUN: begin
                    if (!i_flush) begin
                        acc    <= acc_nxt;
                        mplier <= mplier_nxt;
                        cnt    <= cnt - CNT_W'(1);
                    end
                end
                MULT_DONE: begin
                    hi_q <= product[2*WIDTH-1:WIDTH];
                    lo_q <= product[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    // The product is visible during DONE itself so HI/LO can capture it alongside the strobe.
    assign o_hi = (state == MULT_DONE) ? product[2*WIDTH-1:WIDTH] : hi_q;
    assign o_lo = (state == MULT_DONE) ? product[WIDTH-1:0]       : lo_q;

endmodule

// File: tb/tb_hilo_mult_seq.sv
// tb/tb_hilo_mult_seq.sv - self-checking bench for hilo_mult_seq
module tb_hilo_mult_seq;

    logic        clk = 1'b0;
    logic        rst, start, sgn, flush;
    logic [31:0] a, b;
    logic        stall, busy, we;
    logic [31:0] hi, lo;
    logic        stall1, busy1, we1, stall4, busy4, we4;
    logic [31:0] hi1, lo1, hi4, lo4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hilo_mult_seq #(.WIDTH(32), .BITS_PER_CYCLE(2)) u_dut (
        .clk(clk), .rst(rst), .i_start(start), .i_signed(sgn),
        .i_srcLeft(a), .i_srcRight(b), .i_flush(flush),
        .o_stall(stall), .o_busy(busy), .o_hiloWriteEnable(we), .o_hi(hi), .o_lo(lo));

    hilo_mult_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_b1 (
        .clk(clk), .rst(rst), .i_start(start), .i_signed(sgn),
        .i_srcLeft(a), .i_srcRight(b), .i_flush(flush),
        .o_stall(stall1), .o_busy(busy1), .o_hiloWriteEnable(we1), .o_hi(hi1), .o_lo(lo1));

    hilo_mult_seq #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_b4 (
        .clk(clk), .rst(rst), .i_start(start), .i_signed(sgn),
        .i_srcLeft(a), .i_srcRight(b), .i_flush(flush),
        .o_stall(stall4), .o_busy(busy4), .o_hiloWriteEnable(we4), .o_hi(hi4), .o_lo(lo4));

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy;
        logic [63:0] ux, uy;
        sx = $signed({{32{x[31]}}, x});
        sy = $signed({{32{y[31]}}, y});
        ux = {32'b0, x};
        uy = {32'b0, y};
        return s ? 64'(sx * sy) : ux * uy;
    endfunction

    // Cycles from the start cycle to the write strobe for the default 2-bit-per-cycle build.
    function automatic int exp_lat(input logic s, input logic [31:0] y);
`ifdef MULT_EARLY_OUT_EN
        logic [31:0] mag;
        int digits;
        mag = (s && y[31]) ? (32'd0 - y) : y;
        digits = 1;
        while (digits < 16 && (mag >> (2 * digits)) != 0) digits++;
        return digits + 1;
`else
        return 17 + 0 * int'(s) + 0 * int'(y[0]);
`endif
    endfunction

    task automatic run_op(input logic s, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] rh, output logic [31:0] rl,
                          output int lat, output int stalls);
        @(negedge clk);
        sgn = s; a = x; b = y; start = 1'b1;
        #1 chk("start_stall", {63'b0, stall}, 64'd1);
        @(negedge clk);
        start = 1'b0;
        lat = 1; stalls = 0;
        while (!we && lat < 100) begin
            if (stall) stalls++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) chk("strobe_timeout", 64'd0, 64'd1);
        chk("done_stall", {63'b0, stall}, 64'd0);
        rh = hi; rl = lo;
        @(negedge clk);
        chk("strobe_one_cycle", {63'b0, we}, 64'd0);
        chk("hold_hilo", {hi, lo}, {rh, rl});
    endtask

    task automatic wait_all_idle();
        int n = 0;
        while ((busy || busy1 || busy4) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [31:0] rh, rl, ph, pl;
        logic [63:0] exp;
        int lat, stalls, l1, l2, l4, flush_at;

        vecs[0] = '{1'b0, 32'h0000FFFF, 32'h00010001, 32'h00000000, 32'hFFFFFFFF};
        vecs[1] = '{1'b1, 32'hFFFFFFFF, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFF9};
        vecs[2] = '{1'b0, 32'hFFFFFFFF, 32'h00000007, 32'h00000006, 32'hFFFFFFF9};
        vecs[3] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[4] = '{1'b1, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[5] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[6] = '{1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
        vecs[7] = '{1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000};
        vecs[8] = '{1'b0, 32'h12345678, 32'h00000003, 32'h00000000, 32'h369D0368};

        rst = 1'b1; start = 1'b0; sgn = 1'b0; flush = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {hi, lo}, 64'd0);
        chk("reset_flags", {61'b0, stall, busy, we}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, rh, rl, lat, stalls);
            chk($sformatf("vec%0d_product", i), {rh, rl}, {vecs[i].hi, vecs[i].lo});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].s, vecs[i].b)));
            chk($sformatf("vec%0d_stalls", i), 64'(stalls), 64'(exp_lat(vecs[i].s, vecs[i].b) - 1));
        end

        for (int i = 0; i < 20; i++) begin
            logic s;
            logic [31:0] x, y;
            s = 1'($urandom);
            x = $urandom;
            y = (i % 5 == 4) ? 32'd0 : $urandom;
            if (i % 7 == 3) y = $urandom_range(0, 255);
            exp = model(s, x, y);
            run_op(s, x, y, rh, rl, lat, stalls);
            chk($sformatf("rand%0d_product", i), {rh, rl}, exp);
            chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(exp_lat(s, y)));
        end

        // Same operands through all three digit widths.
        wait_all_idle();
        sgn = 1'b1; a = 32'h80000000; b = 32'h80000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        l1 = 0; l2 = 0; l4 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (we && l2 == 0) begin l2 = c; chk("bpc2_product", {hi, lo}, 64'h40000000_00000000); end
            if (we1 && l1 == 0) begin l1 = c; chk("bpc1_product", {hi1, lo1}, 64'h40000000_00000000); end
            if (we4 && l4 == 0) begin l4 = c; chk("bpc4_product", {hi4, lo4}, 64'h40000000_00000000); end
            @(negedge clk);
        end
        chk("bpc2_latency", 64'(l2), 64'd17);
        chk("bpc1_latency", 64'(l1), 64'd33);
        chk("bpc4_latency", 64'(l4), 64'd9);
        wait_all_idle();

        // Flush in the middle of RUN: no write, HI/LO unchanged, stall drops the same cycle.
`ifdef MULT_EARLY_OUT_EN
        flush_at = 1;
`else
        flush_at = 4;
`endif
        ph = hi; pl = lo;
        @(negedge clk);
        sgn = 1'b1; a = 32'd5; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < flush_at; c++) begin
            chk("flush_no_strobe", {63'b0, we}, 64'd0);
            @(negedge clk);
        end
        flush = 1'b1;
        #1 chk("flush_stall_drop", {62'b0, stall, busy}, 64'd1);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("flush_idle", {62'b0, busy, we}, 64'd0);
        chk("flush_hilo_kept", {hi, lo}, {ph, pl});
        run_op(1'b1, 32'd6, 32'd7, rh, rl, lat, stalls);
        chk("restart_product", {rh, rl}, 64'h0000_0000_0000_002A);

        // Flush together with start in IDLE: no start.
        @(negedge clk);
        start = 1'b1; flush = 1'b1;
        #1 chk("flush_start_stall", {63'b0, stall}, 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1 chk("flush_start_busy", {63'b0, busy}, 64'd0);

        // Flush during DONE still writes.
        @(negedge clk);
        sgn = 1'b0; a = 32'd3; b = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!we && lat < 100) begin @(negedge clk); lat++; end
        flush = 1'b1;
        #1 chk("flush_done_we", {63'b0, we}, 64'd1);
        chk("flush_done_product", {hi, lo}, 64'd12);
        @(negedge clk);
        flush = 1'b0;
        #1 chk("flush_done_hold", {hi, lo}, 64'd12);

        // Reset mid-RUN, with a start in the same cycle.
        wait_all_idle();
        @(negedge clk);
        sgn = 1'b0; a = 32'h1234; b = 32'h00FF00FF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1 chk("rst_mid_hilo", {hi, lo}, 64'd0);
        chk("rst_mid_flags", {61'b0, stall, busy, we}, 64'd0);
        @(negedge clk);
        chk("rst_start_ignored", {63'b0, busy}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
